write_ptr_full: RTL and testbench

Write-domain pointer and full-flag generator for the asynchronous FIFO. It sits directly upstream of the dual-port FIFO memory and drives that memory's `write_address` and `full` inputs. It also publishes a Gray-coded write pointer for the read domain and synchronizes the read domain's Gray pointer into `write_clk`. From that pointer it derives full, almost-full, fill level and a sticky overflow flag.

---
 rtl/write_ptr_full.sv | 88 ++++++++
 tb/tb_write_ptr_full.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/write_ptr_full.sv
// Write-domain side of an asynchronous FIFO: binary/Gray write pointer, read-pointer
// synchronizer, and registered full / almost-full / fill-level / sticky overflow flags.
module write_ptr_full #(
    parameter int address_width         = 4,
    parameter int almost_full_threshold = 14,
    parameter int sync_stages           = 2
) (
    input  logic                     write_clk,
    input  logic                     write_rst,
    input  logic                     wr,
    input  logic [address_width:0]   read_ptr_gray,
    input  logic                     clear_overflow,
    output logic [address_width-1:0] write_address,
    output logic [address_width:0]   write_ptr_gray,
    output logic                     full,
    output logic                     almost_full,
    output logic [address_width:0]   fill_level,
    output logic                     overflow
);

    localparam int AW = address_width;
    localparam logic [AW:0] AF_THRESHOLD = (AW+1)'(almost_full_threshold);

    function automatic logic [AW:0] gray_to_bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW:0]                  bin_q, bin_d;
    logic [AW:0]                  gray_q, gray_d;
    logic [AW:0]                  level_q, level_d;
    logic [sync_stages-1:0][AW:0] sync_q;
    logic [AW:0]                  rq, rbin;
    logic                         full_q, full_d;
    logic                         af_q, af_d;
    logic                         ovf_q, ovf_d;
    logic                         accept;

    always_comb begin
        rq      = sync_q[sync_stages-1];
        rbin    = gray_to_bin(rq);
        accept  = wr & ~full_q;
        bin_d   = bin_q + {{AW{1'b0}}, accept};
        gray_d  = bin_d ^ (bin_d >> 1);
        // Fill is computed against the lagging synchronized read pointer, so it can only over-report.
        level_d = bin_d - rbin;
        full_d  = (gray_d == {~rq[AW:AW-1], rq[AW-2:0]});
        af_d    = (level_d >= AF_THRESHOLD);
        ovf_d   = ovf_q;
        if (wr && full_q) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge write_clk or posedge write_rst) begin
        if (write_rst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            level_q <= '0;
            sync_q  <= '0;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            sync_q  <= {sync_q[sync_stages-2:0], read_ptr_gray};
            full_q  <= full_d;
            af_q    <= af_d;
            ovf_q   <= ovf_d;
        end
    end

    assign write_address  = bin_q[AW-1:0];
    assign write_ptr_gray = gray_q;
    assign full           = full_q;
    assign almost_full    = af_q;
    assign fill_level     = level_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_write_ptr_full.sv
// Bench for write_ptr_full: vector table for fill/overflow/drain, hand sequences for reset,
// wrap-around and reset mid-fill, and randomized traffic against a counting model.
module tb_write_ptr_full;

    localparam int AW = 4;
    localparam int D  = 16;
    localparam int M  = 32;

    logic          write_clk = 1'b0;
    logic          write_rst;
    logic          wr;
    logic [AW:0]   read_ptr_gray;
    logic          clear_overflow;
    logic [AW-1:0] write_address;
    logic [AW:0]   write_ptr_gray;
    logic          full;
    logic          almost_full;
    logic [AW:0]   fill_level;
    logic          overflow;

    write_ptr_full #(
        .address_width(AW),
        .almost_full_threshold(14),
        .sync_stages(2)
    ) dut (
        .write_clk(write_clk),
        .write_rst(write_rst),
        .wr(wr),
        .read_ptr_gray(read_ptr_gray),
        .clear_overflow(clear_overflow),
        .write_address(write_address),
        .write_ptr_gray(write_ptr_gray),
        .full(full),
        .almost_full(almost_full),
        .fill_level(fill_level),
        .overflow(overflow)
    );

    always #5 write_clk = ~write_clk;

    int checks = 0;
    int errors = 0;

    // Model: total accepted writes mod 2^(aw+1), and a delay line of read pointer values.
    int m_w;
    int m_fill;
    bit m_full;
    bit m_af;
    bit m_ovf;
    int sq[$];
    int cur_r;

    typedef struct {
        bit w;
        int r;
        bit c;
        int addr;
        int fill;
        bit full;
        bit af;
        bit ovf;
        int gray;
    } vec_t;

    vec_t tbl[24];

    function automatic logic [AW:0] to_gray(input int b);
        logic [AW:0] v;
        v = b[AW:0];
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_w    = 0;
        m_fill = 0;
        m_full = 0;
        m_af   = 0;
        m_ovf  = 0;
        sq     = '{0, 0};
    endtask

    task automatic check_model();
        chk("model_addr", int'(write_address), m_w % D);
        chk("model_gray", int'(write_ptr_gray), int'(to_gray(m_w)));
        chk("model_full", int'(full), int'(m_full));
        chk("model_afull", int'(almost_full), int'(m_af));
        chk("model_fill", int'(fill_level), m_fill);
        chk("model_ovf", int'(overflow), int'(m_ovf));
    endtask

    task automatic step(input bit w, input int r, input bit c);
        int rseen;
        wr             = w;
        cur_r          = r;
        read_ptr_gray  = to_gray(r);
        clear_overflow = c;
        @(posedge write_clk);
        #1;
        rseen = sq[0];
        void'(sq.pop_front());
        sq.push_back(r);
        if (w && m_full)  m_ovf = 1;
        else if (c)       m_ovf = 0;
        if (w && !m_full) m_w = (m_w + 1) % M;
        m_fill = (m_w - rseen + M) % M;
        m_full = (m_fill == D);
        m_af   = (m_fill >= 14);
        check_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, int'(write_address), 0);
        chk({tag, "_gray"}, int'(write_ptr_gray), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_afull"}, int'(almost_full), 0);
        chk({tag, "_fill"}, int'(fill_level), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    task automatic do_reset();
        @(negedge write_clk);
        write_rst      = 1'b1;
        wr             = 1'b0;
        clear_overflow = 1'b0;
        read_ptr_gray  = '0;
        cur_r          = 0;
        #1;
        m_reset();
        @(negedge write_clk);
        write_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW:0] prev_gray;
        int r;

        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{w: 1, r: 0, c: 0, addr: (i + 1) % D, fill: i + 1, full: (i == 15),
                       af: (i + 1 >= 14), ovf: 0, gray: (i + 1) ^ ((i + 1) >> 1)};
        end
        for (int i = 16; i < 19; i++) begin
            tbl[i] = '{w: 1, r: 0, c: 0, addr: 0, fill: 16, full: 1, af: 1, ovf: 1, gray: 'h18};
        end
        tbl[19] = '{w: 0, r: 0, c: 1, addr: 0, fill: 16, full: 1, af: 1, ovf: 0, gray: 'h18};
        tbl[20] = '{w: 1, r: 0, c: 1, addr: 0, fill: 16, full: 1, af: 1, ovf: 1, gray: 'h18};
        tbl[21] = '{w: 0, r: 1, c: 0, addr: 0, fill: 16, full: 1, af: 1, ovf: 1, gray: 'h18};
        tbl[22] = '{w: 0, r: 1, c: 0, addr: 0, fill: 16, full: 1, af: 1, ovf: 1, gray: 'h18};
        tbl[23] = '{w: 0, r: 1, c: 0, addr: 0, fill: 15, full: 0, af: 1, ovf: 1, gray: 'h18};

        // Power-on reset, asynchronous
        write_rst      = 1'b1;
        wr             = 1'b0;
        clear_overflow = 1'b0;
        read_ptr_gray  = '0;
        cur_r          = 0;
        m_reset();
        #12;
        check_all_zero("por");
        @(negedge write_clk);
        write_rst = 1'b0;

        // Reset asserted mid-cycle clears outputs before the next edge
        for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
        @(negedge write_clk);
        write_rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        m_reset();
        @(negedge write_clk);
        write_rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0);
        check_all_zero("idle_after_rst");

        // Fill, overflow, clear, and drain visibility
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].w, tbl[i].r, tbl[i].c);
            chk($sformatf("vec%0d_addr", i), int'(write_address), tbl[i].addr);
            chk($sformatf("vec%0d_fill", i), int'(fill_level), tbl[i].fill);
            chk($sformatf("vec%0d_full", i), int'(full), int'(tbl[i].full));
            chk($sformatf("vec%0d_afull", i), int'(almost_full), int'(tbl[i].af));
            chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
            chk($sformatf("vec%0d_gray", i), int'(write_ptr_gray), tbl[i].gray);
        end

        // Wrap-around with the reader trailing one behind
        do_reset();
        prev_gray = write_ptr_gray;
        for (int i = 0; i < 40; i++) begin
            r = (i == 0) ? 0 : (i - 1) % M;
            step(1'b1, r, 1'b0);
            chk("wrap_addr", int'(write_address), (i + 1) % D);
            chk("wrap_full", int'(full), 0);
            chk("wrap_gray_1bit", $countones(write_ptr_gray ^ prev_gray), 1);
            prev_gray = write_ptr_gray;
        end

        // Reset in the middle of a fill
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 0, 1'b0);
        @(negedge write_clk);
        write_rst = 1'b1;
        #1;
        chk("midrst_addr", int'(write_address), 0);
        chk("midrst_fill", int'(fill_level), 0);
        chk("midrst_full", int'(full), 0);
        m_reset();
        #1;
        write_rst     = 1'b0;
        read_ptr_gray = '0;
        wr            = 1'b1;
        #1;
        chk("midrst_first_addr", int'(write_address), 0);
        step(1'b1, 0, 1'b0);

        // Randomized traffic: write-heavy phase then read-heavy phase
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit w;
            bit c;
            int wp;
            int rp;
            wp = (i < 200) ? 80 : 30;
            rp = (i < 200) ? 30 : 80;
            w  = ($urandom_range(0, 99) < wp);
            c  = ($urandom_range(0, 15) == 0);
            r  = cur_r;
            if (r != m_w && $urandom_range(0, 99) < rp) r = (r + 1) % M;
            step(w, r, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
